ahb_master_fpga: RTL

- AHB-Lite initiator that drives the two FPGA AHB slaves from board switches and a start button.
- Latches a command (slave select, direction, start address, burst type, length, write seed byte) and runs a single or burst transfer with correct address/data-phase pipelining.
- Read data is returned on an 8-bit output for the seven-segment path.
- Byte transfers only (hsize = 0).

---
 rtl/ahb_master_pkg.sv | 37 +++
 rtl/ahb_burst_addr_gen.sv | 27 ++
 rtl/ahb_master_fpga.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ahb_master_pkg.sv
// Shared AHB-Lite constants, FSM state encodings and the burst beat-count helper
// for the FPGA AHB initiator.
package ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_LAST = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

  // Number of beats (1..16) implied by an hburst code; len only matters for INCR.
  function automatic logic [4:0] beats_of(input logic [2:0] hburst, input logic [3:0] len);
    case (hburst)
      HBURST_SINGLE:               beats_of = 5'd1;
      HBURST_INCR:                 beats_of = {1'b0, len} + 5'd1;
      HBURST_WRAP4, HBURST_INCR4:  beats_of = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  beats_of = 5'd8;
      default:                     beats_of = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Combinational next-beat address: full increment for INCR types, low-bit wrap
// (upper bits held) for WRAP4/8/16.
module ahb_burst_addr_gen
  import ahb_master_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr = addr + ADDR_W'(1);
    case (burst)
      HBURST_WRAP4:  wrap_mask = ADDR_W'(4'h3);
      HBURST_WRAP8:  wrap_mask = ADDR_W'(4'h7);
      HBURST_WRAP16: wrap_mask = ADDR_W'(4'hF);
      default:       wrap_mask = '1;
    endcase
    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
  end

endmodule

// File: rtl/ahb_master_fpga.sv
// AHB-Lite initiator driven by board switches and a start button.
// Define RD_BUF_EN to add a 16x8 read-beat buffer (rd_idx in, rd_buf_data out).
module ahb_master_fpga
  import ahb_master_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              start,
  input  logic              cmd_slave,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic              hsel_1,
  output logic              hsel_2,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
`ifdef RD_BUF_EN
  input  logic [3:0]        rd_idx,
  output logic [DATA_W-1:0] rd_buf_data,
`endif
  output logic              err
);

  localparam logic [4:0] MAX_BEATS = 5'(MAX_LEN);

  state_t            state;
  logic              start_q;
  logic              launch;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        last_idx;
  logic [3:0]        addr_idx;
  logic              dp_valid;
  logic              rd_capture;
  logic [4:0]        beats_req;
  logic [ADDR_W-1:0] next_addr;

  assign launch     = start & ~start_q & (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign rd_capture = dp_valid & hready & ~hresp & ~hwrite;

  always_comb begin
    beats_req = beats_of(cmd_burst, cmd_len);
    if (beats_req > MAX_BEATS) beats_req = MAX_BEATS;
  end

  ahb_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (haddr),
    .burst     (hburst),
    .next_addr (next_addr)
  );

  // dp_valid marks a beat in its data phase; an address beat only advances on hready.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      hsel_1   <= 1'b0;
      hsel_2   <= 1'b0;
      haddr    <= '0;
      htrans   <= HTRANS_IDLE;
      hwrite   <= 1'b0;
      hburst   <= HBURST_SINGLE;
      hwdata   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wdata_q  <= '0;
      last_idx <= '0;
      addr_idx <= '0;
      dp_valid <= 1'b0;
    end else begin
      start_q  <= start;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (rd_capture) begin
        rd_data  <= hrdata;
        rd_valid <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_ADDR;
            hsel_1   <= ~cmd_slave;
            hsel_2   <= cmd_slave;
            hwrite   <= cmd_write;
            hburst   <= cmd_burst;
            haddr    <= cmd_addr;
            htrans   <= HTRANS_NONSEQ;
            wdata_q  <= cmd_wdata;
            last_idx <= 4'(beats_req - 5'd1);
            addr_idx <= '0;
            dp_valid <= 1'b0;
            err      <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (dp_valid && hresp && !hready) begin
            htrans   <= HTRANS_IDLE;
            dp_valid <= 1'b0;
            state    <= ST_ERR;
          end else if (hready) begin
            dp_valid <= 1'b1;
            hwdata   <= wdata_q + DATA_W'(addr_idx);
            if (addr_idx == last_idx) begin
              htrans <= HTRANS_IDLE;
              state  <= ST_LAST;
            end else begin
              addr_idx <= addr_idx + 4'd1;
              haddr    <= next_addr;
              htrans   <= HTRANS_SEQ;
            end
          end
        end
        ST_LAST: begin
          if (hresp && !hready) begin
            dp_valid <= 1'b0;
            state    <= ST_ERR;
          end else if (hready) begin
            dp_valid <= 1'b0;
            hsel_1   <= 1'b0;
            hsel_2   <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          // Second cycle of the two-cycle ERROR response.
          if (hready) begin
            err    <= 1'b1;
            done   <= 1'b1;
            hsel_1 <= 1'b0;
            hsel_2 <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef RD_BUF_EN
  logic [DATA_W-1:0] rd_buf [16];
  logic [3:0]        data_idx;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      data_idx    <= '0;
      rd_buf_data <= '0;
    end else begin
      if (state == ST_ADDR && hready) data_idx <= addr_idx;
      rd_buf_data <= rd_buf[rd_idx];
    end
  end

  always_ff @(posedge hclk) begin
    if (rd_capture) rd_buf[data_idx] <= hrdata;
  end
`endif

endmodule
